// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and 512-bit block output of the SHA-256 message padder.
// The slave modport is the padder; the master modport is whoever feeds bytes and consumes blocks.
interface sha256_msg_padder_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    modport master (
        output in_data, in_valid, in_last, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last
    );

    modport slave (
        input  in_data, in_valid, in_last, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream big-endian into 512-bit SHA-256 blocks and appends
// FIPS 180-4 padding (0x80, zero fill, 64-bit bit length), tagging first/last blocks.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    sha256_msg_padder_if.slave  bus
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_DONE} state_t;

    state_t             state;
    state_t             cont;
    logic [6:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic               first;
    logic               pend80;
    logic               in_ready_q;
    logic               blk_valid_q;
    logic               blk_first_q;
    logic               blk_last_q;

    logic [7:0]         mem [64];
    logic [511:0]       blk_flat;
    logic [63:0]        len64;

    logic               wr_en;
    logic               len_wr;
    logic [5:0]         wr_idx;
    logic [7:0]         wr_byte;
    logic               accept;

    assign accept = bus.in_valid && in_ready_q;
    assign len64  = 64'({cnt, 3'b000});

    // NOTE: every signal driven from always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        len_wr  = 1'b0;
        wr_idx  = idx[5:0];
        wr_byte = bus.in_data;
        if (!clear) begin
            case (state)
                S_FILL: wr_en = accept;
                S_PAD: begin
                    if (!idx[6]) begin
                        if (idx == 7'd56 && !pend80) begin
                            len_wr = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_byte = pend80 ? 8'h80 : 8'h00;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the block buffer is a plain storage array with no reset; every byte is written before it is emitted.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_byte;
        if (len_wr) begin
            for (int i = 0; i < 8; i++) mem[6'(56 + i)] <= len64[63 - 8*i -: 8];
        end
    end

    always_comb begin
        blk_flat = '0;
        for (int i = 0; i < 64; i++) blk_flat[511 - 8*i -: 8] = mem[i];
    end

    // Gating keeps blk_data at zero outside EMIT without a second 512-bit register.
    assign bus.blk_data  = blk_valid_q ? blk_flat : '0;
    assign bus.in_ready  = in_ready_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FILL;
            cont        <= S_FILL;
            idx         <= '0;
            cnt         <= '0;
            first       <= 1'b1;
            pend80      <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else if (clear) begin
            state       <= S_FILL;
            cont        <= S_FILL;
            idx         <= '0;
            cnt         <= '0;
            first       <= 1'b1;
            pend80      <= 1'b0;
            in_ready_q  <= 1'b1;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept) begin
                        idx <= idx + 7'd1;
                        cnt <= cnt + CNT_W'(1);
                        if (bus.in_last) begin
                            state      <= S_PAD;
                            pend80     <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (idx == 7'd63) begin
                            state       <= S_EMIT;
                            cont        <= S_FILL;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_first_q <= first;
                            blk_last_q  <= 1'b0;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_PAD: begin
                    if (idx[6]) begin
                        state       <= S_EMIT;
                        cont        <= S_PAD;
                        blk_valid_q <= 1'b1;
                        blk_first_q <= first;
                        blk_last_q  <= 1'b0;
                    end else if (idx == 7'd56 && !pend80) begin
                        idx         <= 7'd64;
                        state       <= S_EMIT;
                        cont        <= S_DONE;
                        blk_valid_q <= 1'b1;
                        blk_first_q <= first;
                        blk_last_q  <= 1'b1;
                    end else begin
                        pend80 <= 1'b0;
                        idx    <= idx + 7'd1;
                    end
                end
                S_EMIT: begin
                    if (bus.blk_ready) begin
                        idx         <= '0;
                        first       <= 1'b0;
                        blk_valid_q <= 1'b0;
                        blk_first_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        if (cont == S_DONE) begin
                            cnt        <= '0;
                            first      <= 1'b1;
                            state      <= S_FILL;
                            in_ready_q <= 1'b1;
                        end else begin
                            state      <= cont;
                            in_ready_q <= (cont == S_FILL);
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule
